// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable frame format and a small receive FIFO.
// Each FIFO entry holds {data, parity error, framing error} for one frame.
module uart_rx_cfg #(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Sin,
    input  logic                 Received,
    output logic                 Receive,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] SAMPLE_PT = TW'(BAUD_DIV / 2);
    localparam logic [TW-1:0] LAST_CNT  = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] CNT_ONE   = TW'(1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_INC   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_INC   = AW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    logic                 sin_meta_q, ss_q;
    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic                 push_q, push_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 sample;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 overrun_q;
    logic                 fifo_full, fifo_empty, pop, wr_en;
    logic [EW-1:0]        head;

    // Two-flop synchroniser; reset to the idle line level so no false start is seen.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sin_meta_q <= 1'b1;
            ss_q       <= 1'b1;
        end else begin
            sin_meta_q <= Sin;
            ss_q       <= sin_meta_q;
        end
    end

    assign sample = (cnt_q == SAMPLE_PT);

    // Control state: FSM, bit timer, bit index and the delayed push strobe.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            push_q  <= push_d;
        end
    end

    // Frame contents; they only matter once push_q qualifies them.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        perr_q <= perr_d;
        ferr_q <= ferr_d;
    end

    // Next-state logic: the timer free-runs outside IDLE and all decisions happen at mid-bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_ONE;
        idx_d   = idx_q;
        push_d  = 1'b0;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!ss_q) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    if (ss_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (idx_q == 4'(i)) data_d[i] = ss_q;
                    end
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (sample) begin
                    // Even: data plus parity must XOR to 0; odd: to 1.
                    perr_d  = (PARITY == 1) ? (^data_q ^ ss_q) : ~(^data_q ^ ss_q);
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (sample) begin
                    if (!ss_q) ferr_d = 1'b1;
                    if (idx_q == LAST_STOP) begin
                        // Back in IDLE right away so a following start bit is not missed.
                        state_d = IDLE;
                        push_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign pop        = Received && !fifo_empty;
    // A full FIFO still accepts a push when the head is popped on the same edge.
    assign wr_en      = push_q && (!fifo_full || pop);

    // FIFO pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_INC;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_INC;
            if (wr_en && !pop)      count_q <= count_q + CNT_INC;
            else if (!wr_en && pop) count_q <= count_q - CNT_INC;
            if (push_q && !wr_en)   overrun_q <= 1'b1;
        end
    end

    // FIFO storage; when full with a pop, the slot written is the one being vacated.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {data_q, perr_q, ferr_q};
    end

    assign head      = mem_q[rd_ptr_q];
    assign Receive   = !fifo_empty;
    assign Dout      = fifo_empty ? '0 : head[EW-1:2];
    assign parityErr = fifo_empty ? 1'b0 : head[1];
    assign frameErr  = fifo_empty ? 1'b0 : head[0];
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8O1 instance and a 7N2 instance, both at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int BD = 16;

    logic       clk;
    logic       Reset = 1'b1;
    logic       sin_a = 1'b1, sin_b = 1'b1;
    logic       Received_a = 1'b0, Received_b = 1'b0;
    logic       Receive_a, parityErr_a, frameErr_a, overrun_a, busy_a;
    logic       Receive_b, parityErr_b, frameErr_b, overrun_b, busy_b;
    logic [7:0] Dout_a;
    logic [6:0] Dout_b;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    ent_t q_a[$];
    ent_t q_b[$];
    ent_t e_a, e_b;
    int   total = 0;
    int   bad   = 0;
    logic auto_a = 1'b1, popreq_a = 1'b0, blind_a = 1'b0;

    uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .Reset(Reset), .Sin(sin_a), .Received(Received_a),
        .Receive(Receive_a), .Dout(Dout_a), .parityErr(parityErr_a),
        .frameErr(frameErr_a), .overrun(overrun_a), .busy(busy_a));

    uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .Reset(Reset), .Sin(sin_b), .Received(Received_b),
        .Receive(Receive_b), .Dout(Dout_b), .parityErr(parityErr_b),
        .frameErr(frameErr_b), .overrun(overrun_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor A: compares the head entry against the scoreboard whenever it pops.
    initial forever begin
        @(negedge clk);
        if (blind_a) begin
            Received_a = 1'b1;
        end else if (Receive_a === 1'b1 && (auto_a || popreq_a)) begin
            if (q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_a_unexpected: got Dout=%h pe=%b fe=%b with nothing expected",
                         Dout_a, parityErr_a, frameErr_a);
            end else begin
                e_a = q_a.pop_front();
                check("mon_a_entry", {5'b0, 1'b0, Dout_a, parityErr_a, frameErr_a},
                      {5'b0, e_a.d, e_a.pe, e_a.fe});
            end
            Received_a = 1'b1;
        end else begin
            Received_a = 1'b0;
        end
    end

    // Monitor B: always pops and checks.
    initial forever begin
        @(negedge clk);
        if (Receive_b === 1'b1) begin
            if (q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_b_unexpected: got Dout=%h pe=%b fe=%b with nothing expected",
                         Dout_b, parityErr_b, frameErr_b);
            end else begin
                e_b = q_b.pop_front();
                check("mon_b_entry", {5'b0, 2'b0, Dout_b, parityErr_b, frameErr_b},
                      {5'b0, e_b.d, e_b.pe, e_b.fe});
            end
            Received_b = 1'b1;
        end else begin
            Received_b = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic bit_a(input logic v);
        sin_a = v;
        cyc(BD);
    endtask

    task automatic bit_b(input logic v);
        sin_b = v;
        cyc(BD);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic p, input logic s, input int idle);
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(d[i]);
        bit_a(p);
        bit_a(s);
        sin_a = 1'b1;
        if (idle > 0) cyc(idle);
    endtask

    task automatic frame_b(input logic [6:0] d, input logic s1, input logic s2, input int idle);
        bit_b(1'b0);
        for (int i = 0; i < 7; i++) bit_b(d[i]);
        bit_b(s1);
        bit_b(s2);
        sin_b = 1'b1;
        if (idle > 0) cyc(idle);
    endtask

    task automatic exp_a(input logic [7:0] d, input logic pe, input logic fe);
        ent_t e;
        e.d  = {1'b0, d};
        e.pe = pe;
        e.fe = fe;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input logic [6:0] d, input logic pe, input logic fe);
        ent_t e;
        e.d  = {2'b0, d};
        e.pe = pe;
        e.fe = fe;
        q_b.push_back(e);
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while (q_a.size() != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        check(name, 16'(q_a.size()), 16'd0);
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while (q_b.size() != 0 && n < 2000) begin
            cyc(1);
            n++;
        end
        check(name, 16'(q_b.size()), 16'd0);
    endtask

    logic [7:0] pats [3];

    initial begin
        pats[0] = 8'h00;
        pats[1] = 8'hFF;
        pats[2] = 8'h81;

        // Reset state
        Reset = 1'b1;
        cyc(3);
        check("rst_receive", 16'(Receive_a), 16'd0);
        check("rst_dout", 16'(Dout_a), 16'd0);
        check("rst_parityerr", 16'(parityErr_a), 16'd0);
        check("rst_frameerr", 16'(frameErr_a), 16'd0);
        check("rst_overrun", 16'(overrun_a), 16'd0);
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_b_receive", 16'(Receive_b), 16'd0);
        Reset = 1'b0;
        cyc(2);

        // Pops on an empty FIFO are ignored
        blind_a = 1'b1;
        cyc(4);
        blind_a = 1'b0;
        cyc(1);
        check("empty_pop_receive", 16'(Receive_a), 16'd0);

        // Good frame
        exp_a(8'hA5, 1'b0, 1'b0);
        frame_a(8'hA5, odd_par(8'hA5), 1'b1, 16);
        drain_a("drain_a5");
        check("a5_receive_low", 16'(Receive_a), 16'd0);

        // Parity error then framing error
        exp_a(8'h3C, 1'b1, 1'b0);
        exp_a(8'h3C, 1'b0, 1'b1);
        frame_a(8'h3C, ~odd_par(8'h3C), 1'b1, 16);
        frame_a(8'h3C, odd_par(8'h3C), 1'b0, 48);
        drain_a("drain_3c");

        // Back-to-back frames with edge data patterns
        for (int i = 0; i < 3; i++) begin
            exp_a(pats[i], 1'b0, 1'b0);
            frame_a(pats[i], odd_par(pats[i]), 1'b1, 0);
        end
        cyc(16);
        drain_a("drain_pats");

        // Short low glitch: start seen, then rejected with nothing stored
        sin_a = 1'b0;
        cyc(5);
        sin_a = 1'b1;
        cyc(3);
        check("glitch_busy_start", 16'(busy_a), 16'd1);
        cyc(12);
        check("glitch_busy_idle", 16'(busy_a), 16'd0);
        check("glitch_receive", 16'(Receive_a), 16'd0);

        // Five frames into a four-entry FIFO with no pops
        auto_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_a(8'(i), 1'b0, 1'b0);
            frame_a(8'(i), odd_par(8'(i)), 1'b1, 0);
        end
        cyc(20);
        check("ovr_set", 16'(overrun_a), 16'd1);
        check("ovr_full_receive", 16'(Receive_a), 16'd1);
        auto_a = 1'b1;
        drain_a("drain_ovr");
        check("ovr_sticky", 16'(overrun_a), 16'd1);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        cyc(1);
        check("ovr_cleared", 16'(overrun_a), 16'd0);

        // Push and pop on the same edge while full
        auto_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a(8'h11 + 8'(i), 1'b0, 1'b0);
            frame_a(8'h11 + 8'(i), odd_par(8'h11 + 8'(i)), 1'b1, 0);
        end
        cyc(4);
        exp_a(8'h15, 1'b0, 1'b0);
        fork
            frame_a(8'h15, odd_par(8'h15), 1'b1, 8);
            begin
                int n;
                n = 0;
                while (busy_a !== 1'b1 && n < 100) begin
                    cyc(1);
                    n++;
                end
                n = 0;
                while (busy_a !== 1'b0 && n < 400) begin
                    cyc(1);
                    n++;
                end
                check("pp_busy_fall", 16'(busy_a), 16'd0);
                popreq_a = 1'b1;
                cyc(1);
                popreq_a = 1'b0;
            end
        join
        check("pp_no_overrun", 16'(overrun_a), 16'd0);
        check("pp_still_full", 16'(Receive_a), 16'd1);
        auto_a = 1'b1;
        drain_a("drain_pp");

        // Reset in the middle of data bit 3 discards the frame
        bit_a(1'b0);
        bit_a(1'b1);
        bit_a(1'b1);
        bit_a(1'b0);
        sin_a = 1'b0;
        cyc(8);
        sin_a = 1'b1;
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        check("midrst_busy", 16'(busy_a), 16'd0);
        check("midrst_receive", 16'(Receive_a), 16'd0);
        cyc(40);
        exp_a(8'h5A, 1'b0, 1'b0);
        frame_a(8'h5A, odd_par(8'h5A), 1'b1, 16);
        drain_a("drain_5a");

        // 7 data bits, no parity, two stop bits
        exp_b(7'h55, 1'b0, 1'b0);
        frame_b(7'h55, 1'b1, 1'b1, 16);
        exp_b(7'h55, 1'b0, 1'b1);
        frame_b(7'h55, 1'b1, 1'b0, 48);
        exp_b(7'h2A, 1'b0, 1'b1);
        frame_b(7'h2A, 1'b0, 1'b1, 48);
        exp_b(7'h7F, 1'b0, 1'b0);
        frame_b(7'h7F, 1'b1, 1'b1, 16);
        drain_b("drain_b");
        check("b_overrun", 16'(overrun_b), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per bit period; legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 2, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, range 2..16.
REQ-006 clk  input  1  Clock; all state updates on rising edge.
REQ-007 Reset  input  1  Reset; synchronous, active-high.
REQ-008 Sin  input  1  Asynchronous serial line; idles high.
REQ-009 Received  input  1  Pop request; consumes the FIFO head entry.
REQ-010 Receive  output  1  High while the FIFO is non-empty.
REQ-011 Dout  output  DATA_BITS  Data of the FIFO head entry.
REQ-012 parityErr  output  1  Parity-error flag of the FIFO head entry.
REQ-013 frameErr  output  1  Framing-error flag of the FIFO head entry.
REQ-014 overrun  output  1  Sticky flag: a frame was dropped because the FIFO was full.
REQ-015 busy  output  1  High whenever the FSM is not in IDLE.

Function
REQ-016 Sin SHALL pass through a 2-flop synchroniser; all internal sampling uses the synchronised value (ss).
REQ-017 FSM states SHALL be IDLE, START, DATA, PAR, STOP; any other encoding transitions to IDLE.
REQ-018 Bit timer SHALL count 0..BAUD_DIV-1, clear on entry to START, and wrap to 0 after BAUD_DIV-1; its sample point is count == BAUD_DIV/2 (integer division).
REQ-019 IDLE: ss==0 SHALL move the FSM to START.
REQ-020 START: at the sample point, ss==1 SHALL return the FSM to IDLE (glitch rejection, nothing written); ss==0 SHALL move it to DATA with bit index 0.
REQ-021 DATA: SHALL sample ss at each subsequent sample point into data bit [index], LSB first; after bit DATA_BITS-1 it moves to PAR if PARITY!=0, otherwise to STOP.
REQ-022 PAR: SHALL sample the parity bit; perr = XOR(data, parity bit) for even, XNOR for odd.
REQ-023 STOP: SHALL sample STOP_BITS stop bits at successive sample points; ferr is set if any sampled stop bit is 0.
REQ-024 After the last stop sample, the next cycle SHALL push {data, perr, ferr} into the FIFO and return the FSM to IDLE, so back-to-back frames are received with no idle gap.
REQ-025 PARITY==0 SHALL force perr=0.
REQ-026 Push while full without a same-cycle pop SHALL drop the frame and set overrun; overrun clears only on Reset.
REQ-027 Simultaneous push and pop while full SHALL accept both; overrun is not set.
REQ-028 Received while empty SHALL be ignored; pointers and count are unchanged.
REQ-029 Outputs SHALL be registered or taken directly from FIFO storage; Dout, parityErr and frameErr are 0 while Receive==0.
REQ-030 Pop SHALL take effect on the clk edge where Received==1 and Receive==1; the next entry appears the following cycle.

Reset
REQ-031 Reset SHALL force: FSM to IDLE, timer and bit index to 0, synchroniser flops to 1, FIFO empty, overrun 0.
REQ-032 Reset SHALL dominate all other inputs, including mid-frame; a partial frame is discarded and never pushed.
REQ-033 After Reset: Receive=0, Dout=0, parityErr=0, frameErr=0, overrun=0, busy=0.

Verification (BAUD_DIV=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4 unless stated)
REQ-034 Send 0xA5 with correct odd parity and stop=1 -> Receive rises; Dout=0xA5, parityErr=0, frameErr=0; pulse Received -> Receive=0.
REQ-035 Send 0x3C with the wrong parity bit, then 0x3C with stop bit 0 -> head entry {0x3C, perr=1, ferr=0}; next entry {0x3C, perr=0, ferr=1}.
REQ-036 Drive a 5-cycle low pulse on Sin -> FSM returns to IDLE; no push; Receive stays 0.
REQ-037 Send 5 back-to-back frames 0x01..0x05 with no pops -> FIFO holds 0x01..0x04, overrun=1; pushing while popping on a full FIFO leaves overrun unchanged.
REQ-038 Assert Reset at the 4th data bit -> busy=0, Receive=0 next cycle; a following 0x5A frame is received correctly.
REQ-039 DATA_BITS=7, PARITY=0, STOP_BITS=2 with 0x55 -> Dout=0x55; a second stop bit of 0 -> frameErr=1.
